// File: rtl/ring_phase_monitor_if.sv
// Bus bundle between a ring-counter source and ring_phase_monitor.
// master drives the ring sample and clear; slave returns phase/lock status.
interface ring_phase_monitor_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REV_W = 8,
  parameter int unsigned ERR_W = 4
);
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] ring_in;
  logic             clr;
  logic [IDX_W-1:0] phase_idx;
  logic             locked;
  logic             fault;
  logic             wrap_pulse;
  logic [REV_W-1:0] rev_count;
  logic [ERR_W-1:0] err_count;

  modport master (
    output ring_in, clr,
    input  phase_idx, locked, fault, wrap_pulse, rev_count, err_count
  );

  modport slave (
    input  ring_in, clr,
    output phase_idx, locked, fault, wrap_pulse, rev_count, err_count
  );
endinterface

// File: rtl/ring_phase_monitor.sv
// Checks a rotate-left one-hot ring for correct sequencing, encodes the phase,
// counts revolutions and faults. Optional macro RING_STALL_OK_EN allows holds.
module ring_phase_monitor #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned REV_W    = 8,
  parameter int unsigned ERR_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ring_phase_monitor_if.slave  bus
);
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED, FAULT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] ring_q;
  logic [CNT_W-1:0] good_cnt, good_d;
  logic [IDX_W-1:0] phase_q, phase_d, enc;
  logic             locked_q, fault_q, wrap_q, wrap_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic [ERR_W-1:0] err_q, err_d, err_base;
  logic [WIDTH-1:0] ring_rot;
  logic             onehot, adv, hold, wrap, fault_ev;

  assign ring_rot = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
  assign onehot   = (bus.ring_in != '0) &&
                    ((bus.ring_in & (bus.ring_in - WIDTH'(1))) == '0);
  assign adv      = onehot && (bus.ring_in == ring_rot);
  assign wrap     = ring_q[WIDTH-1] && bus.ring_in[0];

`ifdef RING_STALL_OK_EN
  assign hold = onehot && (bus.ring_in == ring_q);
`else
  assign hold = 1'b0;
`endif

  // Binary encode of the incoming one-hot sample
  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.ring_in[i]) enc = IDX_W'(i);
    end
  end

  // Next-state, counters and output next-values
  always_comb begin
    state_d  = state;
    good_d   = good_cnt;
    wrap_d   = 1'b0;
    fault_ev = 1'b0;
    unique case (state)
      IDLE: begin
        if (onehot) begin
          state_d = SYNC;
          good_d  = '0;
        end
      end
      SYNC: begin
        if (!onehot) begin
          state_d = IDLE;
          good_d  = '0;
        end else if (adv) begin
          if (good_cnt == CNT_W'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_cnt + CNT_W'(1);
          end
        end else if (!hold) begin
          good_d = '0;
        end
      end
      LOCKED: begin
        if (adv) begin
          wrap_d = wrap && !bus.clr;
        end else if (!hold) begin
          state_d  = FAULT;
          fault_ev = 1'b1;
        end
      end
      FAULT: begin
        if (bus.clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rev_d    = bus.clr ? '0 : (wrap_d ? rev_q + REV_W'(1) : rev_q);
    err_base = bus.clr ? '0 : err_q;
    err_d    = (fault_ev && (err_base != '1)) ? err_base + ERR_W'(1) : err_base;
    phase_d  = (state_d == IDLE) ? '0 : enc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ring_q   <= '0;
      good_cnt <= '0;
      phase_q  <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      wrap_q   <= 1'b0;
      rev_q    <= '0;
      err_q    <= '0;
    end else begin
      state    <= state_d;
      ring_q   <= bus.ring_in;
      good_cnt <= good_d;
      phase_q  <= phase_d;
      locked_q <= (state_d == LOCKED);
      fault_q  <= (state_d == FAULT);
      wrap_q   <= wrap_d;
      rev_q    <= rev_d;
      err_q    <= err_d;
    end
  end

  assign bus.phase_idx  = phase_q;
  assign bus.locked     = locked_q;
  assign bus.fault      = fault_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.rev_count  = rev_q;
  assign bus.err_count  = err_q;
endmodule
